// File: rtl/stair_pkg.sv
// Shared definitions for the stair animator: FSM encoding, screen limits,
// colour constants and a counter-width helper.
package stair_pkg;

   // Encodings are visible on current_state; 6 and 7 are unused.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_DRAW  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ERASE = 3'd4,
      ST_MOVE  = 3'd5
   } state_t;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] RED   = 3'b100;

   // Bits needed to hold values 0..n-1 (never less than one bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // A pixel is drawable only inside the 160x120 frame.
   function automatic logic on_screen(input int px, input int py);
      return (px < SCREEN_W) && (py < SCREEN_H);
   endfunction

endpackage

// File: rtl/stair_scan.sv
// Pixel scanner shared by the DRAW and ERASE passes. x_off runs fastest,
// then y_off, then the stair index. While enabled it advances one pixel per
// cycle and wraps to zero after the last pixel; while disabled it sits at
// zero so the next pass starts from the first pixel. The next-count values
// are exported so the parent can register the pixel on the same edge the
// counters advance.
module stair_scan
   import stair_pkg::*;
#(
   parameter int NUM_STAIRS = 4,
   parameter int STAIR_W    = 40,
   parameter int STAIR_H    = 5,
   parameter int XW         = cnt_w(STAIR_W),
   parameter int YW         = cnt_w(STAIR_H),
   parameter int IW         = cnt_w(NUM_STAIRS)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          en,
   output logic [XW-1:0] x_off,
   output logic [YW-1:0] y_off,
   output logic [IW-1:0] idx,
   output logic          last,
   output logic [XW-1:0] nx_off,
   output logic [YW-1:0] ny_off,
   output logic [IW-1:0] nidx
);

   logic [XW-1:0] x_off_q, x_off_d;
   logic [YW-1:0] y_off_q, y_off_d;
   logic [IW-1:0] idx_q,   idx_d;
   logic          x_end, y_end, i_end;

   assign x_end = (x_off_q == XW'(STAIR_W - 1));
   assign y_end = (y_off_q == YW'(STAIR_H - 1));
   assign i_end = (idx_q   == IW'(NUM_STAIRS - 1));

   // Next pixel position: nested wrap of x, then y, then stair index.
   always_comb begin
      x_off_d = '0;
      y_off_d = '0;
      idx_d   = '0;
      if (en) begin
         x_off_d = x_off_q;
         y_off_d = y_off_q;
         idx_d   = idx_q;
         if (!x_end) begin
            x_off_d = x_off_q + 1'b1;
         end else begin
            x_off_d = '0;
            if (!y_end) begin
               y_off_d = y_off_q + 1'b1;
            end else begin
               y_off_d = '0;
               idx_d   = i_end ? '0 : idx_q + 1'b1;
            end
         end
      end
   end

   // Scan position registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_off_q <= '0;
         y_off_q <= '0;
         idx_q   <= '0;
      end else begin
         x_off_q <= x_off_d;
         y_off_q <= y_off_d;
         idx_q   <= idx_d;
      end
   end

   assign x_off  = x_off_q;
   assign y_off  = y_off_q;
   assign idx    = idx_q;
   assign last   = x_end && y_end && i_end;
   assign nx_off = x_off_d;
   assign ny_off = y_off_d;
   assign nidx   = idx_d;

endmodule

// File: rtl/multi_stair_animator.sv
// Animates NUM_STAIRS rectangular stairs that climb one row per move and
// wrap from row 0 back to Y_WRAP. Each move is: draw every stair, wait a
// number of frame ticks, erase every stair, shift all tops up by one.
// Optional feature macro: STAIR_COLOUR_CYCLE_EN -- when defined, stair i is
// drawn in colour (i mod 7)+1 instead of red.
// Pixel port: (x, y, colour) is valid when plot=1; a one-cycle pulse per
// pixel, no back-pressure. Outputs always show the pixel addressed by the
// scan position held in the same cycle.
module multi_stair_animator
   import stair_pkg::*;
#(
   parameter int NUM_STAIRS      = 4,
   parameter int STAIR_W         = 40,
   parameter int STAIR_H         = 5,
   parameter int X_BASE          = 20,
   parameter int X_STEP          = 30,
   parameter int Y_INIT          = 40,
   parameter int Y_SPACING       = 25,
   parameter int Y_WRAP          = 116,
   parameter int FRAME_DELAY     = 833334,
   parameter int FRAMES_PER_STEP = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        go,
   input  logic        hold,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic [2:0]  current_state,
   output logic [15:0] step_count
);

   localparam int XW = cnt_w(STAIR_W);
   localparam int YW = cnt_w(STAIR_H);
   localparam int IW = cnt_w(NUM_STAIRS);
   localparam int DW = cnt_w(FRAME_DELAY);
   localparam int FW = cnt_w(FRAMES_PER_STEP);

   localparam logic [DW-1:0] DLY_RELOAD = DW'(FRAME_DELAY - 1);
   localparam logic [FW-1:0] FRM_LAST   = FW'(FRAMES_PER_STEP - 1);

   state_t        state_q, state_d;
   logic [7:0]    x_q, x_d;
   logic [6:0]    y_q, y_d;
   logic [2:0]    colour_q, colour_d;
   logic          plot_q, plot_d;
   logic [15:0]   step_q, step_d;
   logic [DW-1:0] delay_q, delay_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [6:0]    top_q [NUM_STAIRS];
   logic [6:0]    top_d [NUM_STAIRS];

   logic          scan_en;
   logic [XW-1:0] x_off, nx_off;
   logic [YW-1:0] y_off, ny_off;
   logic [IW-1:0] idx, nidx;
   logic          scan_last;

   // Counters advance only while a DRAW or ERASE pass is in progress.
   assign scan_en = (state_q == ST_DRAW) || (state_q == ST_ERASE);

   stair_scan #(
      .NUM_STAIRS (NUM_STAIRS),
      .STAIR_W    (STAIR_W),
      .STAIR_H    (STAIR_H),
      .XW         (XW),
      .YW         (YW),
      .IW         (IW)
   ) u_scan (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (scan_en),
      .x_off   (x_off),
      .y_off   (y_off),
      .idx     (idx),
      .last    (scan_last),
      .nx_off  (nx_off),
      .ny_off  (ny_off),
      .nidx    (nidx)
   );

   // Next state, frame timing, stair tops and the pixel to register.
   always_comb begin
      int px;
      int py;
      state_d  = state_q;
      delay_d  = delay_q;
      frame_d  = frame_q;
      step_d   = step_q;
      for (int i = 0; i < NUM_STAIRS; i++) begin
         top_d[i] = top_q[i];
      end
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      px       = 0;
      py       = 0;

      case (state_q)
         ST_IDLE: begin
            if (go) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (!go) state_d = ST_DRAW;
         end
         ST_DRAW: begin
            if (scan_last) begin
               state_d = ST_WAIT;
               delay_d = DLY_RELOAD;
               frame_d = '0;
            end
         end
         ST_WAIT: begin
            if (!hold) begin
               if (delay_q == '0) begin
                  delay_d = DLY_RELOAD;
                  if (frame_q == FRM_LAST) begin
                     frame_d = '0;
                     state_d = ST_ERASE;
                  end else begin
                     frame_d = frame_q + 1'b1;
                  end
               end else begin
                  delay_d = delay_q - 1'b1;
               end
            end
         end
         ST_ERASE: begin
            if (scan_last) state_d = ST_MOVE;
         end
         ST_MOVE: begin
            for (int i = 0; i < NUM_STAIRS; i++) begin
               top_d[i] = (top_q[i] == 7'd0) ? 7'(Y_WRAP) : top_q[i] - 7'd1;
            end
            step_d  = step_q + 16'd1;
            state_d = ST_DRAW;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Register the pixel that the scanner will hold next cycle, using the
      // tops as they will stand then (MOVE updates them on the same edge).
      if ((state_d == ST_DRAW) || (state_d == ST_ERASE)) begin
         px = X_BASE + int'(nidx) * X_STEP + int'(nx_off);
         py = int'(top_d[nidx]) + int'(ny_off);
         x_d    = px[7:0];
         y_d    = py[6:0];
         plot_d = on_screen(px, py);
         if (state_d == ST_ERASE) begin
            colour_d = BLACK;
         end else begin
`ifdef STAIR_COLOUR_CYCLE_EN
            colour_d = 3'((int'(nidx) % 7) + 1);
`else
            colour_d = RED;
`endif
         end
      end
   end

   // State, counters, stair tops and pixel outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         step_q   <= '0;
         delay_q  <= '0;
         frame_q  <= '0;
         for (int i = 0; i < NUM_STAIRS; i++) begin
            top_q[i] <= 7'(Y_INIT + i * Y_SPACING);
         end
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         step_q   <= step_d;
         delay_q  <= delay_d;
         frame_q  <= frame_d;
         for (int i = 0; i < NUM_STAIRS; i++) begin
            top_q[i] <= top_d[i];
         end
      end
   end

   assign x             = x_q;
   assign y             = y_q;
   assign colour        = colour_q;
   assign plot          = plot_q;
   assign current_state = state_q;
   assign step_count    = step_q;

endmodule

// File: tb/tb_multi_stair_animator.sv
// Self-checking bench for multi_stair_animator. The reference keeps the
// stair tops as plain integers and derives every expected pixel, WAIT length
// and step count from the animation rules. The wrap row is 120 so that a
// wrapped stair lands on the clipped rows 120-121.
module tb_multi_stair_animator;

   localparam int NS  = 2;
   localparam int SW  = 4;
   localparam int SH  = 2;
   localparam int XB  = 10;
   localparam int XS  = 8;
   localparam int YI  = 5;
   localparam int YS  = 3;
   localparam int YW  = 120;
   localparam int FD  = 3;
   localparam int FPS = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        go = 1'b0;
   logic        hold = 1'b0;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic [2:0]  current_state;
   logic [15:0] step_count;

   int tests = 0;
   int fails = 0;
   int tops[NS];
   int model_steps = 0;

   always #5 clock = ~clock;

   multi_stair_animator #(
      .NUM_STAIRS      (NS),
      .STAIR_W         (SW),
      .STAIR_H         (SH),
      .X_BASE          (XB),
      .X_STEP          (XS),
      .Y_INIT          (YI),
      .Y_SPACING       (YS),
      .Y_WRAP          (YW),
      .FRAME_DELAY     (FD),
      .FRAMES_PER_STEP (FPS)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .go            (go),
      .hold          (hold),
      .x             (x),
      .y             (y),
      .colour        (colour),
      .plot          (plot),
      .current_state (current_state),
      .step_count    (step_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic reset_model();
      for (int i = 0; i < NS; i++) tops[i] = YI + i * YS;
      model_steps = 0;
   endtask

   // Walk one full pass pixel by pixel; go is scrambled since it must be ignored.
   task automatic check_scan(input bit erase);
      int ex, ey, ec;
      for (int i = 0; i < NS; i++) begin
         for (int yo = 0; yo < SH; yo++) begin
            for (int xo = 0; xo < SW; xo++) begin
               ex = XB + i * XS + xo;
               ey = tops[i] + yo;
`ifdef STAIR_COLOUR_CYCLE_EN
               ec = erase ? 0 : (i % 7) + 1;
`else
               ec = erase ? 0 : 4;
`endif
               chk(erase ? "erase_state" : "draw_state", 32'(current_state), erase ? 4 : 2);
               chk("pix_x", 32'(x), ex & 255);
               chk("pix_y", 32'(y), ey & 127);
               chk("pix_colour", 32'(colour), ec);
               chk("pix_plot", 32'(plot), (ex < 160 && ey < 120) ? 1 : 0);
               go = 1'($urandom_range(0, 1));
               tick();
            end
         end
      end
      go = 1'b0;
      chk(erase ? "after_erase_state" : "after_draw_state", 32'(current_state), erase ? 5 : 3);
   endtask

   // WAIT must last FD*FPS cycles plus one per cycle hold is high.
   task automatic check_wait();
      int n, hs, hl;
      n  = 0;
      hs = $urandom_range(1, 4);
      hl = $urandom_range(0, 4);
      while (current_state == 3'd3 && n < 200) begin
         hold = (n >= hs && n < hs + hl);
         chk("wait_plot", 32'(plot), 0);
         tick();
         n++;
      end
      hold = 1'b0;
      chk("wait_len", 32'(n), FD * FPS + hl);
      chk("wait_exit_state", 32'(current_state), 4);
   endtask

   initial begin
      reset_model();
      #3;
      chk("rst_state", 32'(current_state), 0);
      chk("rst_x", 32'(x), 0);
      chk("rst_y", 32'(y), 0);
      chk("rst_colour", 32'(colour), 0);
      chk("rst_plot", 32'(plot), 0);
      chk("rst_steps", 32'(step_count), 0);
      #10;
      reset_n = 1'b1;
      repeat (3) tick();
      chk("idle_no_go", 32'(current_state), 0);

      go = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      chk("arm_state", 32'(current_state), 1);
      go = 1'b0;
      tick();

      // Eight full moves: stair 0 climbs 5..0, wraps to 120 (clipped), then 119.
      for (int m = 0; m < 8; m++) begin
         check_scan(1'b0);
         check_wait();
         check_scan(1'b1);
         chk("move_plot", 32'(plot), 0);
         tick();
         for (int i = 0; i < NS; i++) tops[i] = (tops[i] == 0) ? YW : tops[i] - 1;
         model_steps = (model_steps + 1) % 65536;
         chk("step_count", 32'(step_count), model_steps);
      end

      // Asynchronous reset at the 7th DRAW pixel.
      repeat (6) tick();
      chk("pre_reset_state", 32'(current_state), 2);
      chk("pre_reset_plot", 32'(plot), 1);
      #2;
      reset_n = 1'b0;
      #1;
      reset_model();
      chk("async_state", 32'(current_state), 0);
      chk("async_x", 32'(x), 0);
      chk("async_y", 32'(y), 0);
      chk("async_colour", 32'(colour), 0);
      chk("async_plot", 32'(plot), 0);
      chk("async_steps", 32'(step_count), 0);
      #2;
      reset_n = 1'b1;
      repeat (4) tick();
      chk("restart_needs_go", 32'(current_state), 0);

      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      check_scan(1'b0);
      check_wait();
      check_scan(1'b1);
      tick();
      model_steps = model_steps + 1;
      chk("step_after_restart", 32'(step_count), model_steps);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
